// File: rtl/uart_rx_connector.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_connector
// Brief    : 8N1 UART receiver. It synchronises the RX pin, samples each bit
//            at mid-bit and writes good bytes into the RX FIFO write port.
//            It flags framing and overrun errors and keeps a running count of
//            the bytes written.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_connector #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_RX_uart,
    input  logic        i_full_rx,
    output logic [7:0]  o_RX_DATA,
    output logic        o_wr_rx,
    output logic        o_RX_active,
    output logic        o_frame_err,
    output logic        o_overrun_err,
    output logic [15:0] o_byte_cnt
);

    // Bit-timer width follows from the bit period and is not meant to be overridden.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] c_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_START = 3'd1;
    localparam logic [2:0] c_S_DATA  = 3'd2;
    localparam logic [2:0] c_S_STOP  = 3'd3;
    localparam logic [2:0] c_S_BREAK = 3'd4;

    logic             r_sync1;
    logic             r_sync2;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_timer;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;

    logic             w_rx_s;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_timer_nxt;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_stop_good;
    logic             w_stop_bad;

    assign w_rx_s = r_sync2;

    // Two-flop synchroniser on the asynchronous pin; idles high so reset loads 1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_RX_uart;
            r_sync2 <= r_sync1;
        end
    end

    // Receiver state, bit timer, bit index and shift register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_S_IDLE;
            r_timer <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state logic: the start bit is checked at its middle, and every later
    // sample then falls one full bit period after the previous one.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_stop_good = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = c_S_START;
                    w_timer_nxt = '0;
                end
            end
            c_S_START: begin
                if (r_timer == c_HALF) begin
                    w_timer_nxt = '0;
                    if (!w_rx_s) begin
                        w_state_nxt = c_S_DATA;
                        w_idx_nxt   = 3'd0;
                    end else begin
                        // Start bit no longer low at mid-bit: treat it as a glitch.
                        w_state_nxt = c_S_IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer + c_ONE;
                end
            end
            c_S_DATA: begin
                if (r_timer == c_LAST) begin
                    w_timer_nxt         = '0;
                    w_shift_nxt[r_idx]  = w_rx_s;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = c_S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_timer_nxt = r_timer + c_ONE;
                end
            end
            c_S_STOP: begin
                if (r_timer == c_LAST) begin
                    w_timer_nxt = '0;
                    if (w_rx_s) begin
                        w_stop_good = 1'b1;
                        w_state_nxt = c_S_IDLE;
                    end else begin
                        w_stop_bad  = 1'b1;
                        w_state_nxt = c_S_BREAK;
                    end
                end else begin
                    w_timer_nxt = r_timer + c_ONE;
                end
            end
            c_S_BREAK: begin
                // A held-low line must return high before a new frame can start.
                if (w_rx_s) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // Write / error decision, taken on the stop-bit sample and visible one cycle later.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_RX_DATA     <= 8'h00;
            o_wr_rx       <= 1'b0;
            o_frame_err   <= 1'b0;
            o_overrun_err <= 1'b0;
            o_byte_cnt    <= 16'h0000;
        end else begin
            o_wr_rx       <= w_stop_good & ~i_full_rx;
            o_overrun_err <= w_stop_good & i_full_rx;
            o_frame_err   <= w_stop_bad;
            if (w_stop_good && !i_full_rx) begin
                o_RX_DATA  <= r_shift;
                o_byte_cnt <= o_byte_cnt + 16'd1;
            end
        end
    end

    assign o_RX_active = (r_state != c_S_IDLE) && (r_state != c_S_BREAK);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_connector.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_connector
// Brief    : Self-checking bench for uart_rx_connector. Expected bytes are
//            queued as frames are driven and compared as writes appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_connector;

    localparam int c_CPB = 16;

    logic        clk;
    logic        rst;
    logic        rx;
    logic        full_rx;
    logic [7:0]  rx_data;
    logic        wr_rx;
    logic        rx_active;
    logic        frame_err;
    logic        overrun_err;
    logic [15:0] byte_cnt;

    int n_total = 0;
    int n_bad   = 0;
    int n_wr    = 0;
    int n_ferr  = 0;
    int n_ovr   = 0;
    logic [7:0] sb[$];

    uart_rx_connector #(.CLKS_PER_BIT(c_CPB)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_RX_uart     (rx),
        .i_full_rx     (full_rx),
        .o_RX_DATA     (rx_data),
        .o_wr_rx       (wr_rx),
        .o_RX_active   (rx_active),
        .o_frame_err   (frame_err),
        .o_overrun_err (overrun_err),
        .o_byte_cnt    (byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(c_CPB);
    endtask

    // Drives one 8N1 frame; a good frame with FIFO space is queued as expected.
    task automatic send_byte(input logic [7:0] d, input logic stop);
        if (stop && !full_rx) sb.push_back(d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    // Output monitor: scoreboard comparison on every write, pulse accounting.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wr_rx) begin
                n_wr++;
                if (sb.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
                else chk("rx_data", {24'd0, rx_data}, {24'd0, sb.pop_front()});
            end
            if (frame_err) n_ferr++;
            if (overrun_err) n_ovr++;
            if ((wr_rx && overrun_err) || (frame_err && (wr_rx || overrun_err)))
                chk("pulse_exclusive", 32'd1, 32'd0);
        end
    end

    initial begin
        rst     = 1'b1;
        rx      = 1'b1;
        full_rx = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_data",   {24'd0, rx_data}, 32'd0);
        chk("rst_wr",     {31'd0, wr_rx}, 32'd0);
        chk("rst_active", {31'd0, rx_active}, 32'd0);
        chk("rst_errs",   {30'd0, frame_err, overrun_err}, 32'd0);
        chk("rst_cnt",    {16'd0, byte_cnt}, 32'd0);
        tick(c_CPB);

        // 1: single good frame
        send_byte(8'h55, 1'b1);
        tick(2 * c_CPB);
        chk("t1_wr",    n_wr, 1);
        chk("t1_data",  {24'd0, rx_data}, 32'h55);
        chk("t1_cnt",   {16'd0, byte_cnt}, 32'd1);
        chk("t1_ferr",  n_ferr, 0);

        // 2: back-to-back frames with no idle gap
        send_byte(8'hA3, 1'b1);
        send_byte(8'h0F, 1'b1);
        tick(2 * c_CPB);
        chk("t2_wr",    n_wr, 3);
        chk("t2_data",  {24'd0, rx_data}, 32'h0F);
        chk("t2_cnt",   {16'd0, byte_cnt}, 32'd3);

        // 3: short low glitch on the idle line
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(2 * c_CPB);
        chk("t3_wr",     n_wr, 3);
        chk("t3_errs",   n_ferr + n_ovr, 0);
        chk("t3_active", {31'd0, rx_active}, 32'd0);

        // 4: bad stop bit, line held low, then recovery with a good frame
        send_byte(8'h3C, 1'b0);
        tick(20);
        chk("t4_break_active", {31'd0, rx_active}, 32'd0);
        tick(20);
        rx = 1'b1;
        tick(c_CPB);
        chk("t4_ferr",  n_ferr, 1);
        chk("t4_no_wr", n_wr, 3);
        send_byte(8'h81, 1'b1);
        tick(2 * c_CPB);
        chk("t4_wr",    n_wr, 4);
        chk("t4_data",  {24'd0, rx_data}, 32'h81);
        chk("t4_ferr_once", n_ferr, 1);

        // 5: FIFO full during a good frame, then space again
        full_rx = 1'b1;
        send_byte(8'hE7, 1'b1);
        tick(4);
        full_rx = 1'b0;
        tick(c_CPB);
        chk("t5_ovr",   n_ovr, 1);
        chk("t5_no_wr", n_wr, 4);
        chk("t5_hold",  {24'd0, rx_data}, 32'h81);
        chk("t5_cnt",   {16'd0, byte_cnt}, 32'd4);
        send_byte(8'h18, 1'b1);
        tick(2 * c_CPB);
        chk("t5_wr",    n_wr, 5);
        chk("t5_data",  {24'd0, rx_data}, 32'h18);
        chk("t5_cnt2",  {16'd0, byte_cnt}, 32'd5);

        // 6: reset in the middle of data bit 4, then a clean frame
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b0;
        tick(c_CPB / 2);
        chk("t6_active_before", {31'd0, rx_active}, 32'd1);
        rst = 1'b1;
        rx  = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t6_data",   {24'd0, rx_data}, 32'd0);
        chk("t6_cnt",    {16'd0, byte_cnt}, 32'd0);
        chk("t6_active", {31'd0, rx_active}, 32'd0);
        chk("t6_outs",   {29'd0, wr_rx, frame_err, overrun_err}, 32'd0);
        tick(2 * c_CPB);
        chk("t6_no_wr",  n_wr, 5);
        send_byte(8'h99, 1'b1);
        tick(2 * c_CPB);
        chk("t6_wr",     n_wr, 6);
        chk("t6_data2",  {24'd0, rx_data}, 32'h99);
        chk("t6_cnt2",   {16'd0, byte_cnt}, 32'd1);
        chk("sb_empty",  sb.size(), 0);
        chk("final_errs", n_ferr * 16 + n_ovr, 32'h11);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
